ifu_fetch_stage: RTL and testbench

//  Instruction fetch stage directly upstream of the instruction-bus bridge. Owns the PC,

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_fetch_fifo.sv | 63 ++++++
 rtl/ifu_fetch_stage.sv | 130 +++++++++++++
 tb/tb_ifu_fetch_stage.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch stage: FSM state encoding,
// the {pc, inst} entry buffered toward decode, and address helpers.
package ifu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } ifu_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  localparam logic [31:0] IFU_DEFAULT_RESET_VECTOR = 32'h8000_0000;
  localparam logic [31:0] IFU_WORD_STEP            = 32'd4;

  // Redirect targets may carry low bits; fetch addresses are always word aligned.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch_fifo.sv
// Small circular buffer of fetched {pc, inst} entries toward decode.
// Head is visible combinationally; flush empties it and beats push/pop.
module ifu_fetch_fifo
  import ifu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             entry,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CNT_FULL);
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // Pointer and occupancy bookkeeping; a flush discards everything.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone says what is valid.
  always_ff @(posedge clock) begin
    if (do_push && !flush) mem[wr_ptr] <= entry;
  end

endmodule

// File: rtl/ifu_fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one word fetch at a time on
// the ibus, and buffers {pc, inst} toward decode. Redirects flush the buffer
// and drop any in-flight response (KILL holds the old request until answered).
// Optional build macro IFU_PERF_CNT_EN adds saturating fetch/stall counters.
module ifu_fetch_stage
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = IFU_DEFAULT_RESET_VECTOR,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset,
  output logic        io_bus_req_valid,
  output logic [31:0] io_bus_req_bits,
  input  logic        io_bus_resp_valid,
  output logic        io_bus_resp_ready,
  input  logic [31:0] io_bus_resp_bits,
  output logic        io_out_valid,
  input  logic        io_out_ready,
  output logic [31:0] io_out_bits_pc,
  output logic [31:0] io_out_bits_inst,
  input  logic        io_redirect_valid,
  input  logic [31:0] io_redirect_bits
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] io_perf_fetched,
  output logic [31:0] io_perf_stall
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(FIFO_DEPTH);

  ifu_state_e   state;
  logic [31:0]  pc;
  logic [31:0]  kill_addr;
  logic [31:0]  redirect_target;
  logic         resp_hs;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_full;
  logic         fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [CW-1:0] count_after_push;
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;

  assign redirect_target   = word_align(io_redirect_bits);
  assign io_bus_req_valid  = (state == REQ) || (state == KILL);
  assign io_bus_resp_ready = (state != IDLE);
  assign io_bus_req_bits   = (state == KILL) ? kill_addr : pc;
  assign resp_hs           = io_bus_resp_valid && io_bus_resp_ready;
  assign fifo_push         = (state == REQ) && resp_hs && !io_redirect_valid;
  assign fifo_pop          = io_out_valid && io_out_ready;
  assign count_after_push  = fifo_pop ? fifo_count : fifo_count + CNT_ONE;
  assign push_entry        = '{pc: pc, inst: io_bus_resp_bits};
  assign io_out_valid      = !fifo_empty;
  assign io_out_bits_pc    = head_entry.pc;
  assign io_out_bits_inst  = head_entry.inst;

  ifu_fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (io_redirect_valid),
    .push  (fifo_push),
    .entry (push_entry),
    .pop   (fifo_pop),
    .head  (head_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Fetch FSM: request only with buffer space, redirect kills the in-flight fetch.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      pc        <= RESET_VECTOR;
      kill_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (io_redirect_valid) begin
            pc <= redirect_target;
          end else if (!fifo_full) begin
            state <= REQ;
          end
        end
        REQ: begin
          if (io_redirect_valid) begin
            pc <= redirect_target;
            if (resp_hs) begin
              state <= IDLE;
            end else begin
              kill_addr <= pc;
              state     <= KILL;
            end
          end else if (resp_hs) begin
            pc <= pc + IFU_WORD_STEP;
            if (count_after_push >= CNT_FULL) state <= IDLE;
          end
        end
        KILL: begin
          if (io_redirect_valid) pc <= redirect_target;
          if (resp_hs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef IFU_PERF_CNT_EN
  // Saturating counters: accepted fetches pushed, and cycles waiting on the bus.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      io_perf_fetched <= '0;
      io_perf_stall   <= '0;
    end else begin
      if (fifo_push && (io_perf_fetched != 32'hFFFF_FFFF))
        io_perf_fetched <= io_perf_fetched + 32'd1;
      if (io_bus_req_valid && !io_bus_resp_valid && (io_perf_stall != 32'hFFFF_FFFF))
        io_perf_stall <= io_perf_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ifu_fetch_stage.sv
// Directed self-checking bench for ifu_fetch_stage: streaming, full-buffer
// stop/resume, delayed responses, redirect kill, redirect on handshake, pc wrap.
module tb_ifu_fetch_stage;
  import ifu_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        io_bus_req_valid;
  logic [31:0] io_bus_req_bits;
  logic        io_bus_resp_valid;
  logic        io_bus_resp_ready;
  logic [31:0] io_bus_resp_bits;
  logic        io_out_valid;
  logic        io_out_ready;
  logic [31:0] io_out_bits_pc;
  logic [31:0] io_out_bits_inst;
  logic        io_redirect_valid;
  logic [31:0] io_redirect_bits;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] io_perf_fetched;
  logic [31:0] io_perf_stall;
`endif

  int compared   = 0;
  int mismatched = 0;

  // Instruction word the modelled bridge returns for a given address.
  function automatic logic [31:0] inst_of(input logic [31:0] addr);
    return {addr[15:0], addr[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  assign io_bus_resp_bits = inst_of(io_bus_req_bits);

  ifu_fetch_stage dut (
    .clock             (clock),
    .reset             (reset),
    .io_bus_req_valid  (io_bus_req_valid),
    .io_bus_req_bits   (io_bus_req_bits),
    .io_bus_resp_valid (io_bus_resp_valid),
    .io_bus_resp_ready (io_bus_resp_ready),
    .io_bus_resp_bits  (io_bus_resp_bits),
    .io_out_valid      (io_out_valid),
    .io_out_ready      (io_out_ready),
    .io_out_bits_pc    (io_out_bits_pc),
    .io_out_bits_inst  (io_out_bits_inst),
    .io_redirect_valid (io_redirect_valid),
    .io_redirect_bits  (io_redirect_bits)
`ifdef IFU_PERF_CNT_EN
    ,
    .io_perf_fetched   (io_perf_fetched),
    .io_perf_stall     (io_perf_stall)
`endif
  );

  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset;
    reset = 1'b1;
    io_bus_resp_valid = 1'b0;
    io_out_ready = 1'b0;
    io_redirect_valid = 1'b0;
    io_redirect_bits = 32'h0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    io_bus_resp_valid = 1'b1;
    io_out_ready = 1'b1;
    io_redirect_valid = 1'b0;
    io_redirect_bits = 32'h0;
    tick();
    tick();
    compared++;
    if (io_bus_req_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_req_valid got %b want 0", io_bus_req_valid);
    end
    compared++;
    if (io_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_out_valid got %b want 0", io_out_valid);
    end
    compared++;
    if (io_bus_resp_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL rst_resp_ready got %b want 0", io_bus_resp_ready);
    end
    compared++;
    if (dut.state !== IDLE) begin
      mismatched++;
      $display("[TB] FAIL rst_state got %0d want IDLE", dut.state);
    end
`ifdef IFU_PERF_CNT_EN
    compared++;
    if (io_perf_fetched !== 32'h0 || io_perf_stall !== 32'h0) begin
      mismatched++;
      $display("[TB] FAIL rst_perf got %h/%h want 0/0", io_perf_fetched, io_perf_stall);
    end
`endif
    reset = 1'b0;
  endtask

  task automatic test_streaming;
    logic [31:0] exp_pc;
    do_reset();
    io_bus_resp_valid = 1'b1;
    io_out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      exp_pc = 32'h8000_0000 + 32'(4 * k);
      compared++;
      if (io_bus_req_valid !== 1'b1 || io_bus_req_bits !== exp_pc) begin
        mismatched++;
        $display("[TB] FAIL stream_req%0d got %b/%h want 1/%h", k, io_bus_req_valid, io_bus_req_bits, exp_pc);
      end
      if (k > 0) begin
        exp_pc = 32'h8000_0000 + 32'(4 * (k - 1));
        compared++;
        if (io_out_valid !== 1'b1 || io_out_bits_pc !== exp_pc || io_out_bits_inst !== inst_of(exp_pc)) begin
          mismatched++;
          $display("[TB] FAIL stream_out%0d got %b/%h/%h want 1/%h/%h", k, io_out_valid, io_out_bits_pc, io_out_bits_inst, exp_pc, inst_of(exp_pc));
        end
      end
    end
  endtask

  task automatic test_fifo_full;
    logic resumed;
    do_reset();
    io_bus_resp_valid = 1'b1;
    io_out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (io_bus_req_bits !== 32'h8000_0000 + 32'(4 * k)) begin
        mismatched++;
        $display("[TB] FAIL full_req%0d got %h want %h", k, io_bus_req_bits, 32'h8000_0000 + 32'(4 * k));
      end
    end
    tick();
    compared++;
    if (io_bus_req_valid !== 1'b0 || dut.state !== IDLE) begin
      mismatched++;
      $display("[TB] FAIL full_stop got req_valid=%b state=%0d want 0/IDLE", io_bus_req_valid, dut.state);
    end
    tick();
    compared++;
    if (dut.u_fifo.count !== 3'd4 || io_out_bits_pc !== 32'h8000_0000) begin
      mismatched++;
      $display("[TB] FAIL full_count got %0d/%h want 4/80000000", dut.u_fifo.count, io_out_bits_pc);
    end
    compared++;
    if (io_bus_req_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_hold got req_valid=%b want 0", io_bus_req_valid);
    end
    io_out_ready = 1'b1;
    resumed = 1'b0;
    for (int i = 0; i < 10 && !resumed; i++) begin
      tick();
      if (io_bus_req_valid === 1'b1) resumed = 1'b1;
    end
    compared++;
    if (!resumed || io_bus_req_bits !== 32'h8000_0010) begin
      mismatched++;
      $display("[TB] FAIL full_resume got %b/%h want 1/80000010", resumed, io_bus_req_bits);
    end
  endtask

  task automatic test_delayed_resp;
    do_reset();
    io_bus_resp_valid = 1'b0;
    io_out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      compared++;
      if (io_bus_req_valid !== 1'b1 || io_bus_req_bits !== 32'h8000_0000 || io_out_valid !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL delay_hold%0d got %b/%h/%b want 1/80000000/0", k, io_bus_req_valid, io_bus_req_bits, io_out_valid);
      end
    end
    io_bus_resp_valid = 1'b1;
    tick();
    io_bus_resp_valid = 1'b0;
    compared++;
    if (io_out_valid !== 1'b1 || io_out_bits_pc !== 32'h8000_0000 || io_bus_req_bits !== 32'h8000_0004) begin
      mismatched++;
      $display("[TB] FAIL delay_push got %b/%h/%h want 1/80000000/80000004", io_out_valid, io_out_bits_pc, io_bus_req_bits);
    end
`ifdef IFU_PERF_CNT_EN
    compared++;
    if (io_perf_stall !== 32'd3 || io_perf_fetched !== 32'd1) begin
      mismatched++;
      $display("[TB] FAIL delay_perf got %0d/%0d want stall 3 fetched 1", io_perf_stall, io_perf_fetched);
    end
`endif
  endtask

  task automatic test_redirect_kill;
    do_reset();
    io_bus_resp_valid = 1'b1;
    io_out_ready = 1'b1;
    tick();
    tick();
    tick();
    io_bus_resp_valid = 1'b0;
    io_out_ready = 1'b0;
    tick();
    compared++;
    if (io_bus_req_bits !== 32'h8000_0008 || io_out_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL kill_pre got %h/%b want 80000008/1", io_bus_req_bits, io_out_valid);
    end
    io_redirect_valid = 1'b1;
    io_redirect_bits = 32'h8000_1002;
    tick();
    io_redirect_valid = 1'b0;
    compared++;
    if (dut.state !== KILL || io_bus_req_valid !== 1'b1 || io_bus_req_bits !== 32'h8000_0008 || io_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL kill_state got %0d/%b/%h/%b want KILL/1/80000008/0", dut.state, io_bus_req_valid, io_bus_req_bits, io_out_valid);
    end
    io_bus_resp_valid = 1'b1;
    tick();
    compared++;
    if (io_bus_req_valid !== 1'b0 || io_out_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL kill_drop got %b/%b want 0/0", io_bus_req_valid, io_out_valid);
    end
    tick();
    compared++;
    if (io_bus_req_valid !== 1'b1 || io_bus_req_bits !== 32'h8000_1000) begin
      mismatched++;
      $display("[TB] FAIL kill_target got %b/%h want 1/80001000", io_bus_req_valid, io_bus_req_bits);
    end
    tick();
    compared++;
    if (io_out_valid !== 1'b1 || io_out_bits_pc !== 32'h8000_1000 || io_out_bits_inst !== inst_of(32'h8000_1000)) begin
      mismatched++;
      $display("[TB] FAIL kill_push got %b/%h/%h want 1/80001000/%h", io_out_valid, io_out_bits_pc, io_out_bits_inst, inst_of(32'h8000_1000));
    end
  endtask

  task automatic test_redirect_on_hs;
    do_reset();
    io_bus_resp_valid = 1'b1;
    io_out_ready = 1'b1;
    tick();
    tick();
    io_redirect_valid = 1'b1;
    io_redirect_bits = 32'h8000_2000;
    tick();
    io_redirect_valid = 1'b0;
    compared++;
    if (io_out_valid !== 1'b0 || io_bus_req_valid !== 1'b0 || dut.state !== IDLE) begin
      mismatched++;
      $display("[TB] FAIL hsredir_flush got %b/%b/%0d want 0/0/IDLE", io_out_valid, io_bus_req_valid, dut.state);
    end
    tick();
    compared++;
    if (io_bus_req_valid !== 1'b1 || io_bus_req_bits !== 32'h8000_2000) begin
      mismatched++;
      $display("[TB] FAIL hsredir_target got %b/%h want 1/80002000", io_bus_req_valid, io_bus_req_bits);
    end
  endtask

  task automatic test_pc_wrap;
    do_reset();
    io_bus_resp_valid = 1'b1;
    io_out_ready = 1'b1;
    io_redirect_valid = 1'b1;
    io_redirect_bits = 32'hFFFF_FFFC;
    tick();
    io_redirect_valid = 1'b0;
    tick();
    compared++;
    if (io_bus_req_bits !== 32'hFFFF_FFFC) begin
      mismatched++;
      $display("[TB] FAIL wrap_first got %h want fffffffc", io_bus_req_bits);
    end
    tick();
    compared++;
    if (io_bus_req_bits !== 32'h0000_0000 || io_out_bits_pc !== 32'hFFFF_FFFC) begin
      mismatched++;
      $display("[TB] FAIL wrap_next got %h/%h want 00000000/fffffffc", io_bus_req_bits, io_out_bits_pc);
    end
  endtask

  // Hard time bound so a stuck design still produces a verdict.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_streaming();
    test_fifo_full();
    test_delayed_resp();
    test_redirect_kill();
    test_redirect_on_hs();
    test_pc_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
